xps2rx: RTL
===========

// Module: xps2rx
// PURPOSE
//  PS/2 device-to-host receiver, the input counterpart of xcprint on the controller data bus.
//  Deserialises 11-bit PS/2 frames (start, 8 data LSB-first, odd parity, stop) into scan-code bytes.
//  Buffers the bytes in a small FIFO that xctrl reads through a 2-word register window decoded in xtop.
// PARAMETERS
//  DATA_W          32    data bus width; the byte is zero-extended on reads
//  FIFO_ADDR_W     3     log2 of the FIFO depth (default 8 entries)
//  TIMEOUT_CYC     5000  idle clk cycles before a partial frame is aborted (PS2RX_TIMEOUT_EN only)
// PORTS
//  clk       in   1       system clock
//  rst       in   1       synchronous, active-high reset
//  ps2_clk   in   1       raw PS/2 clock, asynchronous to clk
//  ps2_data  in   1       raw PS/2 data, asynchronous to clk
//  sel       in   1       module select from xtop address decoder
//  we        in   1       write enable (1 = write, 0 = read)
//  addr      in   1       register select: 0 = DATA, 1 = STATUS
//  data_in   in   DATA_W  write data; only [3:1] are used
//  data_out  out  DATA_W  read data, combinational from addr; 0 when sel = 0
// BEHAVIOUR
//  - Synchroniser: ps2_clk and ps2_data each pass through 2 flops. A falling edge (fe) is
//    previous synced clock = 1 and current = 0. Data is sampled on the fe cycle.
//  - FSM with states IDLE, DATA, PARITY, STOP. Reset state is IDLE.
//    IDLE:   on fe with data = 0, clear bit count and go to DATA; on fe with data = 1, stay.
//    DATA:   on fe, shift the bit into shreg[7] (right shift, LSB first) and increment bit count.
//            After the 8th bit, go to PARITY.
//    PARITY: on fe, latch the parity bit and go to STOP.
//    STOP:   on fe, always return to IDLE. Then:
//            - stop bit = 0: set FERR sticky, drop the byte.
//            - otherwise, if XOR(byte, parity) = 0: set PERR sticky, drop the byte.
//            - otherwise, if FIFO full and no pop this cycle: set OVF sticky, drop the byte.
//            - otherwise, push the byte.
//  - Latency: the pushed byte is readable (STATUS.valid = 1) on the cycle after the stop-bit fe.
//  - DATA read (sel & ~we & addr = 0):
//    - data_out = {0, head byte}.
//    - The head is popped at the clk edge of that cycle.
//    - When empty: data_out = 0 and no pointer change.
//  - STATUS read: data_out = {0, count[FIFO_ADDR_W:0] at bits [8+FIFO_ADDR_W:8], FERR[3], PERR[2], OVF[1], valid[0]}.
//  - STATUS write (sel & we & addr = 1): each bit set in data_in[3:1] clears the matching sticky flag.
//    An error event in the same cycle wins (the flag stays set).
//  - DATA writes are ignored.
//  - Simultaneous push and pop:
//    - Allowed at any fill level, including full. count is unchanged.
//    - When empty, the pop is a no-op and the push proceeds.
//  - Pointers wrap modulo 2^FIFO_ADDR_W. count ranges 0..2^FIFO_ADDR_W.
//  - Reset (any cycle, including mid-frame) clears:
//    - FSM to IDLE, shreg and bit count;
//    - FIFO pointers and count, and the sticky flags;
//    - synchroniser flops to 1 (line idle).
//    data_out is 0 after reset until sel is asserted.
// CONFIGURATION
//  PS2RX_TIMEOUT_EN defined:
//    - A counter reloads on every fe and runs while the FSM is not in IDLE.
//    - On reaching TIMEOUT_CYC, the FSM returns to IDLE, FERR is set and the partial byte is discarded.
//  Not defined:
//    - No counter logic. A partial frame waits indefinitely for further edges.
// TESTING
//  1. Frame 0x1C, parity 0, stop 1 -> STATUS = 0x101; DATA read returns 0x1C; then STATUS = 0x000.
//  2. Frame 0x1C with parity 1 -> PERR: STATUS = 0x004, FIFO empty.
//     Write STATUS 0x4 -> STATUS = 0x000.
//  3. Frame with stop bit 0 -> STATUS = 0x008, nothing pushed.
//  4. Nine frames 0x01..0x09 with no reads -> count = 8, OVF set, STATUS = 0x803.
//     Eight reads return 0x01..0x08.
//  5. Pop on the exact cycle of a push while full -> count stays 8 and order is preserved.
//     Also: assert rst after 4 data bits, then send 0x5A -> only 0x5A is read back.
//  6. PS2RX_TIMEOUT_EN: stop ps2_clk after 3 bits for TIMEOUT_CYC cycles -> FERR set, FSM in IDLE.
//     A following 0x33 frame is received correctly.

Source files
------------

// File: rtl/xps2rx_if.sv
// Register-window bus between xctrl and the PS/2 receiver.
// The master side (xctrl/xtop decode) drives select, direction, address and write data.
// The slave side (xps2rx) returns the combinational read data.
interface xps2rx_if #(
  parameter int DATA_W = 32
);
  logic              sel;
  logic              we;
  logic              addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;

  modport master (output sel, output we, output addr, output data_in, input data_out);
  modport slave  (input sel, input we, input addr, input data_in, output data_out);
endinterface

// File: rtl/xps2rx.sv
// xps2rx: PS/2 device-to-host receiver with a small scan-code FIFO.
// Frames (start, 8 data bits LSB first, odd parity, stop) are deserialised on
// falling edges of the synchronised PS/2 clock. Good bytes are pushed into a FIFO
// read through a two-word window: addr 0 = DATA (read pops), addr 1 = STATUS.
// STATUS: count at [8+FIFO_ADDR_W:8], FERR[3], PERR[2], OVF[1], valid[0].
// Optional feature macro: PS2RX_TIMEOUT_EN aborts a partial frame after
// TIMEOUT_CYC clk cycles without a PS/2 clock edge and flags FERR.
module xps2rx #(
  parameter int DATA_W      = 32,
  parameter int FIFO_ADDR_W = 3,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  xps2rx_if.slave    bus
);
  localparam int DEPTH = 1 << FIFO_ADDR_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // Odd parity holds when the data byte plus its parity bit has an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data_byte, input logic par_bit);
    return ^{data_byte, par_bit};
  endfunction

  logic [1:0]             clk_sync_r;
  logic [1:0]             data_sync_r;
  logic                   clk_prev_r;
  logic                   fe_s;
  logic                   bit_s;
  state_t                 state_r;
  state_t                 state_nx_s;
  logic [7:0]             shreg_r;
  logic [3:0]             bit_cnt_r;
  logic                   par_r;
  logic                   clr_cnt_s;
  logic                   shift_s;
  logic                   lat_par_s;
  logic                   done_s;
  logic                   timeout_s;
  logic [7:0]             mem_r [DEPTH];
  logic [FIFO_ADDR_W-1:0] wr_ptr_r;
  logic [FIFO_ADDR_W-1:0] rd_ptr_r;
  logic [FIFO_ADDR_W:0]   count_r;
  logic                   empty_s;
  logic                   full_s;
  logic                   pop_s;
  logic                   push_s;
  logic                   ferr_evt_s;
  logic                   perr_evt_s;
  logic                   ovf_evt_s;
  logic                   clr_wr_s;
  logic                   ferr_r;
  logic                   perr_r;
  logic                   ovf_r;
  logic [DATA_W-1:0]      rd_data_s;

  // Two-flop synchronisers (idle-high) plus a history flop for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_r  <= 2'b11;
      data_sync_r <= 2'b11;
      clk_prev_r  <= 1'b1;
    end else begin
      clk_sync_r  <= {clk_sync_r[0], ps2_clk};
      data_sync_r <= {data_sync_r[0], ps2_data};
      clk_prev_r  <= clk_sync_r[1];
    end
  end

  assign fe_s  = clk_prev_r & ~clk_sync_r[1];
  assign bit_s = data_sync_r[1];

`ifdef PS2RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_r;

  // Idle-cycle counter: restarts on each PS/2 edge, only runs inside a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_r <= '0;
    end else if (fe_s || (state_r == IDLE) || timeout_s) begin
      to_cnt_r <= '0;
    end else begin
      to_cnt_r <= to_cnt_r + TO_W'(1);
    end
  end

  assign timeout_s = (state_r != IDLE) && !fe_s && (to_cnt_r == TO_W'(TIMEOUT_CYC - 1));
  logic unused_s;
  assign unused_s = ^{bus.data_in[DATA_W-1:4], bus.data_in[0]};
`else
  assign timeout_s = 1'b0;
  logic unused_s;
  assign unused_s = ^{bus.data_in[DATA_W-1:4], bus.data_in[0], 1'(TIMEOUT_CYC)};
`endif

  // Frame FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Frame FSM next state and per-edge datapath strobes.
  always_comb begin
    state_nx_s = state_r;
    clr_cnt_s  = 1'b0;
    shift_s    = 1'b0;
    lat_par_s  = 1'b0;
    done_s     = 1'b0;
    if (timeout_s) begin
      state_nx_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (fe_s && !bit_s) begin
            clr_cnt_s  = 1'b1;
            state_nx_s = DATA;
          end else begin
            state_nx_s = IDLE;
          end
        end
        DATA: begin
          if (fe_s) begin
            shift_s = 1'b1;
            if (bit_cnt_r == 4'd7) begin
              state_nx_s = PARITY;
            end else begin
              state_nx_s = DATA;
            end
          end else begin
            state_nx_s = DATA;
          end
        end
        PARITY: begin
          if (fe_s) begin
            lat_par_s  = 1'b1;
            state_nx_s = STOP;
          end else begin
            state_nx_s = PARITY;
          end
        end
        STOP: begin
          if (fe_s) begin
            done_s     = 1'b1;
            state_nx_s = IDLE;
          end else begin
            state_nx_s = STOP;
          end
        end
        default: state_nx_s = IDLE;
      endcase
    end
  end

  // Shift register, bit counter and parity latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_r   <= 8'h00;
      bit_cnt_r <= 4'd0;
      par_r     <= 1'b0;
    end else begin
      if (clr_cnt_s) begin
        bit_cnt_r <= 4'd0;
      end else if (shift_s) begin
        shreg_r   <= {bit_s, shreg_r[7:1]};
        bit_cnt_r <= bit_cnt_r + 4'd1;
      end
      if (lat_par_s) begin
        par_r <= bit_s;
      end
    end
  end

  assign empty_s  = (count_r == '0);
  assign full_s   = (count_r == (FIFO_ADDR_W + 1)'(DEPTH));
  assign pop_s    = bus.sel & ~bus.we & ~bus.addr & ~empty_s;
  assign clr_wr_s = bus.sel & bus.we & bus.addr;

  // Stop-bit outcome: framing error, then parity error, then overflow, else push.
  always_comb begin
    ferr_evt_s = timeout_s;
    perr_evt_s = 1'b0;
    ovf_evt_s  = 1'b0;
    push_s     = 1'b0;
    if (done_s) begin
      if (!bit_s) begin
        ferr_evt_s = 1'b1;
      end else if (!odd_parity_ok(shreg_r, par_r)) begin
        perr_evt_s = 1'b1;
      end else if (full_s && !pop_s) begin
        ovf_evt_s = 1'b1;
      end else begin
        push_s = 1'b1;
      end
    end else begin
      push_s = 1'b0;
    end
  end

  // FIFO storage; a full FIFO popped this cycle frees the slot being written.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= shreg_r;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + FIFO_ADDR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + FIFO_ADDR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (FIFO_ADDR_W + 1)'(1);
        2'b01:   count_r <= count_r - (FIFO_ADDR_W + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky error flags: an event in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      ferr_r <= 1'b0;
      perr_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      ferr_r <= ferr_evt_s | (ferr_r & ~(clr_wr_s & bus.data_in[3]));
      perr_r <= perr_evt_s | (perr_r & ~(clr_wr_s & bus.data_in[2]));
      ovf_r  <= ovf_evt_s  | (ovf_r  & ~(clr_wr_s & bus.data_in[1]));
    end
  end

  // Read mux: zero when unselected or when DATA is read from an empty FIFO.
  always_comb begin
    rd_data_s = '0;
    if (bus.sel) begin
      if (bus.addr) begin
        rd_data_s[8 +: FIFO_ADDR_W + 1] = count_r;
        rd_data_s[3]                    = ferr_r;
        rd_data_s[2]                    = perr_r;
        rd_data_s[1]                    = ovf_r;
        rd_data_s[0]                    = ~empty_s;
      end else if (!empty_s) begin
        rd_data_s[7:0] = mem_r[rd_ptr_r];
      end else begin
        rd_data_s = '0;
      end
    end else begin
      rd_data_s = '0;
    end
  end

  assign bus.data_out = rd_data_s;
endmodule
